// File: rtl/dsa_pkg.sv
// Shared types for the digit-serial adder.
// Holds the controller state encoding used by digit_serial_adder.
package dsa_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } dsa_state_t;

endpackage

// File: rtl/dsa_digit.sv
// Combinational DIGIT-bit ripple adder slice.
// Ports: i_a, i_b (DIGIT bits), i_c carry-in;
//        o_sum (DIGIT bits), o_co carry-out, o_cmsb carry into the MSB.
module dsa_digit #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] i_a,
    input  logic [DIGIT-1:0] i_b,
    input  logic             i_c,
    output logic [DIGIT-1:0] o_sum,
    output logic             o_co,
    output logic             o_cmsb
);

    logic [DIGIT:0] w_c;

    always_comb begin
        w_c      = '0;
        o_sum    = '0;
        w_c[0]   = i_c;
        for (int i = 0; i < DIGIT; i++) begin
            o_sum[i]  = i_a[i] ^ i_b[i] ^ w_c[i];
            w_c[i+1]  = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
        end
    end

    assign o_co   = w_c[DIGIT];
    assign o_cmsb = w_c[DIGIT-1];

endmodule

// File: rtl/digit_serial_adder.sv
// Digit-serial add/subtract: WIDTH-bit operands processed DIGIT bits per
// clock with a valid/ready handshake on both sides.
// Ports: clk, rst (async, active high); in_valid/in_ready, x, y, cin, sub
//        on the input side; out_valid/out_ready, s, cout, ovf on output.
// Option: define DIGIT_SERIAL_ADDER_OVF_EN to compute the signed overflow
//         flag; otherwise ovf is tied to 0.
module digit_serial_adder
    import dsa_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
        $error("digit_serial_adder: WIDTH must be a multiple of DIGIT >= 1");
    end

    localparam int NDIG  = WIDTH / DIGIT;
    localparam int CNT_W = $clog2(NDIG + 1);

    dsa_state_t       r_state;
    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_y;
    logic [WIDTH-1:0] r_s;
    logic             r_c;
    logic [CNT_W-1:0] r_cnt;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_cout;

    logic [DIGIT-1:0] w_sum;
    logic             w_co;
    logic             w_last;
    logic [WIDTH-1:0] w_s_next;

`ifdef DIGIT_SERIAL_ADDER_OVF_EN
    logic r_ovf;
    logic w_cmsb;

    dsa_digit #(.DIGIT(DIGIT)) u_digit (
        .i_a    (r_x[DIGIT-1:0]),
        .i_b    (r_y[DIGIT-1:0]),
        .i_c    (r_c),
        .o_sum  (w_sum),
        .o_co   (w_co),
        .o_cmsb (w_cmsb)
    );

    assign ovf = r_ovf;
`else
    logic w_unused_cmsb;

    dsa_digit #(.DIGIT(DIGIT)) u_digit (
        .i_a    (r_x[DIGIT-1:0]),
        .i_b    (r_y[DIGIT-1:0]),
        .i_c    (r_c),
        .o_sum  (w_sum),
        .o_co   (w_co),
        .o_cmsb (w_unused_cmsb)
    );

    assign ovf = 1'b0;
`endif

    // New digit enters at the top so the LSB digit ends up at the bottom
    // after NDIG shifts.
    assign w_s_next = (r_s >> DIGIT) | (WIDTH'(w_sum) << (WIDTH - DIGIT));
    assign w_last   = (r_cnt == CNT_W'(NDIG - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_x         <= '0;
            r_y         <= '0;
            r_s         <= '0;
            r_c         <= 1'b0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_cout      <= 1'b0;
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
            r_ovf       <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (in_valid && r_in_ready) begin
                        // Subtract is x + ~y + ~cin through the same adder.
                        r_x        <= x;
                        r_y        <= sub ? ~y : y;
                        r_c        <= cin ^ sub;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= RUN;
                    end
                end
                RUN: begin
                    r_x   <= r_x >> DIGIT;
                    r_y   <= r_y >> DIGIT;
                    r_c   <= w_co;
                    r_s   <= w_s_next;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_cout      <= w_co;
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
                        r_ovf       <= w_co ^ w_cmsb;
`endif
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign s         = r_s;
    assign cout      = r_cout;

endmodule

// File: tb/tb_digit_serial_adder.sv
// Scoreboard bench for digit_serial_adder (WIDTH=16, DIGIT=4).
// Reference results come from plain integer add/subtract arithmetic.
module tb_digit_serial_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] x;
    logic [15:0] y;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] s;
    logic        cout;
    logic        ovf;

    always #5 clk = ~clk;

    digit_serial_adder #(.WIDTH(16), .DIGIT(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .cout      (cout),
        .ovf       (ovf)
    );

    typedef struct packed {
        logic [15:0] s;
        logic        c;
        logic        o;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
                     $time);
        end
    endtask

    // Reference: integer arithmetic, signed range test for overflow.
    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                   input logic ci, input logic sb);
        exp_t e;
        int   u;
        int   sv;
        if (sb) begin
            u  = int'(a) - int'(b) - int'(ci);
            sv = int'($signed(a)) - int'($signed(b)) - int'(ci);
            e.c = (u >= 0);
        end else begin
            u  = int'(a) + int'(b) + int'(ci);
            sv = int'($signed(a)) + int'($signed(b)) + int'(ci);
            e.c = (u > 65535);
        end
        e.s = u[15:0];
`ifdef DIGIT_SERIAL_ADDER_OVF_EN
        e.o = (sv > 32767) || (sv < -32768);
`else
        e.o = 1'b0;
`endif
        return e;
    endfunction

    // Monitor: pops on each output transfer, checks holding while stalled.
    initial begin
        exp_t        e;
        logic        pv;
        logic [15:0] ps;
        logic        pc;
        logic        po;
        pv = 1'b0;
        forever begin
            @(negedge clk);
            if (rst || !out_valid) begin
                pv = 1'b0;
            end else begin
                if (pv) begin
                    chk("hold_s", s, ps);
                    chk("hold_cout", cout, pc);
                    chk("hold_ovf", ovf, po);
                    chk("hold_in_ready", in_ready, 0);
                end
                if (out_ready) begin
                    pv = 1'b0;
                    if (q.size() == 0) begin
                        chk("unexpected_result", 1, 0);
                    end else begin
                        e = q.pop_front();
                        chk("s", s, e.s);
                        chk("cout", cout, e.c);
                        chk("ovf", ovf, e.o);
                    end
                end else begin
                    pv = 1'b1;
                    ps = s;
                    pc = cout;
                    po = ovf;
                end
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk("in_ready_wait", in_ready, 1);
    endtask

    task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                         input logic ci, input logic sb, input int hold);
        int lat;
        out_ready = 1'b0;
        wait_ready();
        in_valid = 1'b1;
        x        = a;
        y        = b;
        cin      = ci;
        sub      = sb;
        @(posedge clk);
        q.push_back(model(a, b, ci, sb));
        #2;
        // Garbage while busy must be ignored.
        in_valid = 1'b1;
        x        = 16'($urandom);
        y        = 16'($urandom);
        cin      = 1'($urandom);
        sub      = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #2;
            lat++;
        end
        chk("latency", lat, 4);
        repeat (hold) begin
            @(posedge clk);
            #2;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #2;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("in_ready_after", in_ready, 1);
        chk("out_valid_after", out_valid, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        x         = '0;
        y         = '0;
        cin       = 1'b0;
        sub       = 1'b0;
        #12;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_s", s, 0);
        chk("rst_cout", cout, 0);
        chk("rst_ovf", ovf, 0);
        @(posedge clk);
        #2;
        rst = 1'b0;

        do_op(16'h0002, 16'h0007, 1'b0, 1'b0, 0);
        do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1);
        do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0);
        do_op(16'h0005, 16'h0007, 1'b0, 1'b1, 5);
        do_op(16'h0005, 16'h0007, 1'b1, 1'b1, 2);
        do_op(16'h8000, 16'h0001, 1'b0, 1'b1, 0);
        do_op(16'h8000, 16'h8000, 1'b1, 1'b0, 1);

        // Reset in the second RUN cycle.
        out_ready = 1'b0;
        wait_ready();
        in_valid = 1'b1;
        x        = 16'hAAAA;
        y        = 16'h5555;
        cin      = 1'b1;
        sub      = 1'b0;
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_s", s, 0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        do_op(16'h1234, 16'h1111, 1'b0, 1'b0, 1);

        for (int i = 0; i < 40; i++) begin
            do_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
                  int'($urandom_range(0, 3)));
        end

        repeat (2) @(posedge clk);
        chk("queue_empty", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
